pcm_sample_player: RTL
======================

Name: pcm_sample_player

Overview:
- Upstream feeder for the audio mixer: buffers 8-bit unsigned PCM samples written by the CPU-side port decoder (Covox/SpecDrum-style) in a small FIFO.
- Releases one sample per programmable rate tick and holds it on `sample` for the mixer's 8-bit input.
- Runs entirely on the DAC clock; write strobes arrive already synchronised to `clkdac`.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries).
- RATE_W, 12, width of rate divider.
- DEFAULT_RATE, 12'd874, divider reload value after reset.

Ports:
- clkdac  in  1  DAC/mixer clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  level; 1 = player active, 0 = stop and flush.
- wr_data  in  8  sample byte to push.
- wr_sample  in  1  one-cycle push strobe.
- rate_in  in  RATE_W  new divider value.
- wr_rate  in  1  one-cycle strobe; loads rate_in into rate_q.
- clr_flags  in  1  one-cycle strobe; clears underrun and overflow.
- sample  out  8  current output sample, registered.
- fifo_empty  out  1  level == 0.
- fifo_full  out  1  level == 2**DEPTH_LOG2.
- level  out  DEPTH_LOG2+1  entries held.
- underrun  out  1  sticky: a tick found the FIFO empty.
- overflow  out  1  sticky: a write was dropped because the FIFO was full.

Behaviour:
- Reset values:
  - sample = 0, level = 0, fifo_empty = 1, fifo_full = 0.
  - underrun = 0, overflow = 0.
  - rate_q = DEFAULT_RATE, counter = DEFAULT_RATE, state = IDLE.
- FIFO:
  - Circular buffer; read and write pointers are DEPTH_LOG2 bits wide and wrap.
  - Push when wr_sample && !full. Push when full drops the byte and sets overflow.
  - Pop only on tick in PLAY.
  - Push and pop in the same cycle while full: both succeed, level unchanged.
  - Push and pop in the same cycle while empty: no bypass. The pop sees empty, underrun is set, and the pushed byte is stored.
- States:
  - IDLE: counter held at rate_q; pushes accepted. Go to PRIME when enable = 1.
  - PRIME: counter held at rate_q. Go to PLAY when level >= 2**(DEPTH_LOG2-1).
  - PLAY:
    - Counter decrements each cycle. When counter == 0, tick = 1 and counter reloads rate_q, giving one tick every rate_q+1 cycles.
    - Tick with level > 0: pop; sample <= head at the same edge.
    - Tick with level == 0: sample holds its value; set underrun; go to PRIME.
  - Any state with enable = 0: next edge flushes the FIFO (pointers and level = 0), state = IDLE, sample <= 0.
    - Pushes in that same cycle are discarded.
    - Flush takes priority over a push; disable takes priority over a tick.
- Rate:
  - wr_rate updates rate_q immediately.
  - The running counter is not reloaded, so the new rate applies from the next reload.
  - rate_q = 0 gives a tick every cycle.
- Flags:
  - clr_flags clears both flags.
  - If a setting event occurs in the same cycle as clr_flags, the set wins.
- Latency: sample changes on the same edge that pops. First pop occurs rate_q+1 edges after the edge that entered PLAY.
- Width: level counts 0..2**DEPTH_LOG2 inclusive; no arithmetic saturation is needed elsewhere.

Optional Feature:
- Macro PCM_SILENCE_RAMP_EN.
- Defined:
  - On entering IDLE, sample is not zeroed. Instead it decrements by 1 per divider tick; the counter keeps running in IDLE only while sample != 0, until sample reaches 0.
  - Underrun in PLAY holds sample as normal.
  - Re-enabling during the ramp stops the ramp at its current value.
- Undefined: sample <= 0 on the disable edge, as above.

Test Plan:
- Reset, then inspect outputs -> sample = 0, fifo_empty = 1, level = 0, both flags 0, no ticks while enable = 0.
- rate = 3, enable = 1, push 0x10..0x17 (8 bytes) -> PLAY entered after the 8th push; sample steps 0x10, 0x11, ... every 4 cycles; first change 4 edges after PLAY entry.
- Continue the previous case without pushing -> after 0x17, next tick sets underrun = 1 with sample held at 0x17; state returns to PRIME; clr_flags clears underrun.
- Push 17 bytes with enable = 0 -> level = 16, fifo_full = 1, overflow = 1; the 17th byte is never output.
- FIFO full in PLAY, push on a tick cycle -> level stays 16, no overflow.
- PLAY at sample = 0x05, drop enable -> level = 0 next edge.
  - Without the macro: sample = 0.
  - With PCM_SILENCE_RAMP_EN: sample goes 0x04, 0x03, ..., 0x00 on successive ticks.
- Assert reset mid-PLAY -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pcm_sample_player.sv
// pcm_sample_player
//   Buffers 8-bit unsigned PCM bytes from the CPU-side port decoder in a small
//   circular FIFO and releases one byte per programmable rate tick to the
//   mixer. Everything runs on clkdac; write strobes are already synchronous.
//
// Ports
//   clkdac     : DAC/mixer clock, all logic on posedge
//   reset      : asynchronous, active-high, clears all state
//   enable     : 1 = player active, 0 = stop and flush
//   wr_data    : sample byte to push
//   wr_sample  : one-cycle push strobe
//   rate_in    : new divider value
//   wr_rate    : one-cycle strobe, loads rate_in into the rate register
//   clr_flags  : one-cycle strobe, clears underrun and overflow
//   sample     : current output sample (registered)
//   fifo_empty : level == 0
//   fifo_full  : level == 2**DEPTH_LOG2
//   level      : entries held
//   underrun   : sticky, a tick found the FIFO empty
//   overflow   : sticky, a push was dropped because the FIFO was full
//
// Build option
//   PCM_SILENCE_RAMP_EN : when defined, disabling the player ramps sample down
//   by one per divider tick instead of zeroing it on the disable edge.
module pcm_sample_player #(
  parameter int                DEPTH_LOG2   = 4,
  parameter int                RATE_W       = 12,
  parameter logic [RATE_W-1:0] DEFAULT_RATE = 12'd874
) (
  input  logic                  clkdac,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [7:0]            wr_data,
  input  logic                  wr_sample,
  input  logic [RATE_W-1:0]     rate_in,
  input  logic                  wr_rate,
  input  logic                  clr_flags,
  output logic [7:0]            sample,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  underrun,
  output logic                  overflow
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam int                  LVL_W    = DEPTH_LOG2 + 1;
  localparam logic [LVL_W-1:0]    FULL_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]    HALF_LVL = LVL_W'(DEPTH / 2);

  typedef enum logic [1:0] {IDLE, PRIME, PLAY} state_t;

  state_t                  state, state_nxt;
  logic [7:0]              mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wptr, rptr;
  logic [RATE_W-1:0]       rate_q, counter;

  logic flush, cnt_run, tick, pop, push, ovf_set, unr_set;

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == FULL_LVL);

  // Leaving an active state with enable low flushes; IDLE with enable low is
  // the preload state and keeps accepting pushes.
  always_comb begin
    flush   = !enable && (state != IDLE);
    cnt_run = (state == PLAY);
`ifdef PCM_SILENCE_RAMP_EN
    // Divider keeps running in IDLE only while the silence ramp is active.
    cnt_run = cnt_run || ((state == IDLE) && !enable && (sample != 8'd0));
`endif
    tick    = cnt_run && (counter == '0);
    pop     = (state == PLAY) && tick && !flush && !fifo_empty;
    unr_set = (state == PLAY) && tick && !flush && fifo_empty;
    // A pop in the same cycle frees a slot, so a push while full still lands.
    push    = wr_sample && !flush && (!fifo_full || pop);
    ovf_set = wr_sample && !flush && fifo_full && !pop;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = PRIME;
      PRIME:   if (level >= HALF_LVL) state_nxt = PLAY;
      PLAY:    if (unr_set) state_nxt = PRIME;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clkdac or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Rate divider: held at rate_q unless running; a new rate_q only takes
  // effect at the next reload.
  always_ff @(posedge clkdac or posedge reset) begin
    if (reset) begin
      rate_q  <= DEFAULT_RATE;
      counter <= DEFAULT_RATE;
    end else begin
      if (wr_rate) rate_q <= rate_in;
      if (cnt_run && !flush) begin
        counter <= (counter == '0) ? rate_q : counter - RATE_W'(1);
      end else begin
        counter <= rate_q;
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clkdac or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + DEPTH_LOG2'(1);
      if (pop)  rptr <= rptr + DEPTH_LOG2'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage array carries no reset; only the pointers define its contents.
  always_ff @(posedge clkdac) begin
    if (push) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clkdac or posedge reset) begin
    if (reset) begin
      sample <= 8'd0;
    end else if (flush) begin
`ifdef PCM_SILENCE_RAMP_EN
      sample <= sample;
`else
      sample <= 8'd0;
`endif
    end else if (pop) begin
      sample <= mem[rptr];
`ifdef PCM_SILENCE_RAMP_EN
    end else if ((state == IDLE) && tick) begin
      sample <= sample - 8'd1;
`endif
    end
  end

  // Sticky flags: a set event in the same cycle as clr_flags wins.
  always_ff @(posedge clkdac or posedge reset) begin
    if (reset) begin
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      underrun <= unr_set || (underrun && !clr_flags);
      overflow <= ovf_set || (overflow && !clr_flags);
    end
  end

endmodule
